// File: rtl/run_network_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | run_network_multi                                                        |
// | Multi-class binary-pixel classifier; optional RUN_NETWORK_EARLY_EXIT_EN. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module run_network_multi #(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 7,
  parameter int CLASSES = 3,
  parameter int PASSES  = 4,
  parameter int unsigned MARGIN = 400,
  parameter logic [CLASSES*HEIGHT*(WIDTH+1)-1:0] WEIGHTS =
    {(CLASSES*HEIGHT){(WIDTH+1)'(60)}},
  localparam int BW    = $clog2(HEIGHT*PASSES*2**WIDTH) + 1,
  localparam int c_cw  = $clog2(CLASSES),
  localparam int c_itw = $clog2(HEIGHT*PASSES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [HEIGHT-1:0]    pixels,
  output logic                 busy,
  output logic                 done,
  output logic                 known,
  output logic [c_cw-1:0]      class_idx,
  output logic signed [BW-1:0] balance_out,
  output logic [c_itw-1:0]     iters_out
);

  localparam int c_pw  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int c_ppw = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;

  logic [1:0]           r_state;
  logic [HEIGHT-1:0]    r_pix;
  logic [c_pw-1:0]      r_idx;
  logic [c_ppw-1:0]     r_pass;
  logic [c_itw-1:0]     r_iters;
  logic signed [BW-1:0] r_bal      [CLASSES];
  logic signed [BW-1:0] w_next_bal [CLASSES];

  logic                 w_wrap;
  logic                 w_last;
  logic                 w_exit;
  logic signed [BW-1:0] w_max;
  logic [c_cw-1:0]      w_max_idx;
  logic                 w_tie;

  assign busy   = (r_state == S_RUN) || (r_state == S_DECIDE);
  assign w_wrap = (r_idx == c_pw'(HEIGHT-1));
  assign w_last = w_wrap && (r_pass == c_ppw'(PASSES-1));

  generate
    for (genvar c = 0; c < CLASSES; c++) begin : g_class
      logic signed [WIDTH:0] w_wt;
      assign w_wt = WEIGHTS[(c*HEIGHT + int'(r_idx))*(WIDTH+1) +: (WIDTH+1)];
      assign w_next_bal[c] = r_pix[r_idx] ? (r_bal[c] + BW'(w_wt))
                                          : (r_bal[c] - BW'(w_wt));
    end
  endgenerate

  // Lowest index wins; a later equal value only marks a tie with the current max.
  always_comb begin
    w_max     = r_bal[0];
    w_max_idx = '0;
    w_tie     = 1'b0;
    for (int c = 1; c < CLASSES; c++) begin
      if (r_bal[c] > w_max) begin
        w_max     = r_bal[c];
        w_max_idx = c_cw'(c);
        w_tie     = 1'b0;
      end else if (r_bal[c] == w_max) begin
        w_tie = 1'b1;
      end
    end
  end

`ifdef RUN_NETWORK_EARLY_EXIT_EN
  logic signed [BW-1:0] w_top1;
  logic signed [BW-1:0] w_top2;
  logic [BW:0]          w_lead;

  // Lead is judged on the balances that include the wrapping accumulation.
  always_comb begin
    w_top1 = w_next_bal[0];
    w_top2 = {1'b1, {(BW-1){1'b0}}};
    for (int c = 1; c < CLASSES; c++) begin
      if (w_next_bal[c] > w_top1) begin
        w_top2 = w_top1;
        w_top1 = w_next_bal[c];
      end else if (w_next_bal[c] > w_top2) begin
        w_top2 = w_next_bal[c];
      end
    end
  end

  assign w_lead = {w_top1[BW-1], w_top1} - {w_top2[BW-1], w_top2};
  assign w_exit = w_wrap && (32'(w_lead) >= MARGIN);
`else
  logic w_unused_margin;
  assign w_unused_margin = ^MARGIN;
  assign w_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pix       <= '0;
      r_idx       <= '0;
      r_pass      <= '0;
      r_iters     <= '0;
      done        <= 1'b0;
      known       <= 1'b0;
      class_idx   <= '0;
      balance_out <= '0;
      iters_out   <= '0;
      for (int c = 0; c < CLASSES; c++) r_bal[c] <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pix   <= pixels;
            r_idx   <= '0;
            r_pass  <= '0;
            r_iters <= '0;
            for (int c = 0; c < CLASSES; c++) r_bal[c] <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int c = 0; c < CLASSES; c++) r_bal[c] <= w_next_bal[c];
          r_iters <= r_iters + c_itw'(1);
          if (w_wrap) begin
            r_idx  <= '0;
            r_pass <= r_pass + c_ppw'(1);
          end else begin
            r_idx  <= r_idx + c_pw'(1);
          end
          if (w_last || w_exit) r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          class_idx   <= w_max_idx;
          balance_out <= w_max;
          known       <= !w_tie;
          iters_out   <= r_iters;
          done        <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_network_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_run_network_multi                                                     |
// | Scoreboard bench for run_network_multi (two weight sets).               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_run_network_multi;

`ifdef RUN_NETWORK_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [188:0] W_MAIN = {{7{9'h000}}, {7{9'h1C4}}, {7{9'h03C}}};
  localparam logic [188:0] W_TIE  = {{7{9'h000}}, {7{9'h03C}}, {7{9'h03C}}};

  typedef struct {
    bit     known;
    int     cls;
    int     bal;
    int     iters;
    longint cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [6:0] pixels0 = '0, pixels1 = '0;
  logic busy0, done0, known0, busy1, done1, known1;
  logic [1:0] cls0, cls1;
  logic signed [13:0] bal0, bal1;
  logic [4:0] it0, it1;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  exp_t   q0[$];
  exp_t   q1[$];

  run_network_multi #(.WEIGHTS(W_MAIN)) dut (
    .clk(clk), .rst(rst), .start(start0), .pixels(pixels0),
    .busy(busy0), .done(done0), .known(known0), .class_idx(cls0),
    .balance_out(bal0), .iters_out(it0)
  );

  run_network_multi #(.WEIGHTS(W_TIE)) dut_tie (
    .clk(clk), .rst(rst), .start(start1), .pixels(pixels1),
    .busy(busy1), .done(done1), .known(known1), .class_idx(cls1),
    .balance_out(bal1), .iters_out(it1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL d0_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("d0_known", known0, e.known);
        chk("d0_class_idx", cls0, e.cls);
        chk("d0_balance", $signed(bal0), e.bal);
        chk("d0_iters", it0, e.iters);
        chk("d0_done_cycle", cyc, e.cyc);
        chk("d0_busy_with_done", busy0, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL d1_unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("d1_known", known1, e.known);
        chk("d1_class_idx", cls1, e.cls);
        chk("d1_balance", $signed(bal1), e.bal);
        chk("d1_iters", it1, e.iters);
        chk("d1_done_cycle", cyc, e.cyc);
        chk("d1_busy_with_done", busy1, 0);
      end
    end
  end

  task automatic launch(input int d, input logic [6:0] pix, input bit push,
                        input bit k, input int cls, input int bal,
                        input int it, input int lat);
    exp_t e;
    @(negedge clk);
    if (d == 0) begin pixels0 = pix; start0 = 1'b1; end
    else        begin pixels1 = pix; start1 = 1'b1; end
    e.known = k; e.cls = cls; e.bal = bal; e.iters = it;
    e.cyc   = cyc + 1 + lat;
    if (push) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic drain(input int d, input int bound);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++; failures++;
      $display("FAIL drain_timeout_dut%0d actual=pending expected=empty", d);
      if (d == 0) q0.delete(); else q1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  busy0, 0);
    chk({tag, "_done"},  done0, 0);
    chk({tag, "_known"}, known0, 0);
    chk({tag, "_class"}, cls0, 0);
    chk({tag, "_bal"},   $signed(bal0), 0);
    chk({tag, "_iters"}, it0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // All ones: class 0 leads
    launch(0, 7'h7F, 1'b1, 1'b1, 0, EE ? 420 : 1680, EE ? 7 : 28, EE ? 8 : 29);
    drain(0, 60);
    // All zeros: class 1 leads
    launch(0, 7'h00, 1'b1, 1'b1, 1, EE ? 420 : 1680, EE ? 7 : 28, EE ? 8 : 29);
    drain(0, 60);
    // Mixed patterns with small leads never reach the margin
    launch(0, 7'b0001111, 1'b1, 1'b1, 0, 240, 28, 29);
    drain(0, 60);
    launch(0, 7'b1110000, 1'b1, 1'b1, 1, 240, 28, 29);
    drain(0, 60);
    // Lead 180/pass crosses the margin only after the third pass
    launch(0, 7'b1100000, 1'b1, 1'b1, 1, EE ? 540 : 720, EE ? 21 : 28, EE ? 22 : 29);
    drain(0, 60);

    // Tie between classes 0 and 1
    launch(1, 7'h7F, 1'b1, 1'b0, 0, 1680, 28, 29);
    drain(1, 60);
    // Zero-weight class 2 wins at balance 0
    launch(1, 7'h00, 1'b1, 1'b1, 2, 0, EE ? 7 : 28, EE ? 8 : 29);
    drain(1, 60);

    // Second start while busy is ignored
    if (EE) launch(0, 7'b0001111, 1'b1, 1'b1, 0, 240, 28, 29);
    else    launch(0, 7'h7F, 1'b1, 1'b1, 0, 1680, 28, 29);
    repeat (8) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain(0, 60);
    repeat (40) @(negedge clk);

    // Reset mid-run aborts with no done pulse
    launch(0, 7'b0001111, 1'b0, 1'b0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    rst    = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk_zero("midrun_reset");
    chk("midrun_reset_tie_bal", $signed(bal1), 0);
    chk("midrun_reset_tie_known", known1, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", busy0, 0);
    launch(0, 7'h7F, 1'b1, 1'b1, 0, EE ? 420 : 1680, EE ? 7 : 28, EE ? 8 : 29);
    drain(0, 60);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_network_multi.md
RUN_NETWORK_MULTI -- requirements
Module: run_network_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8: weight magnitude bits; each weight is signed, WIDTH+1 bits.
REQ-002 SHALL have parameter HEIGHT, default 7: number of binary pixel inputs.
REQ-003 SHALL have parameter CLASSES, default 3 (legal range 2..16): number of output classes.
REQ-004 SHALL have parameter PASSES, default 4 (minimum 1): maximum full sweeps over all pixels per run.
REQ-005 SHALL have parameter MARGIN, default 400: early-exit lead threshold, unsigned.
REQ-006 SHALL have parameter WEIGHTS, flat vector of CLASSES*HEIGHT signed (WIDTH+1)-bit fields; field c*HEIGHT+i is the weight of class c for pixel i; default all 9'd60.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-009 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-010 SHALL have port pixels, input, HEIGHT bits: binary inputs, latched when start is accepted.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN and DECIDE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a result is registered.
REQ-013 SHALL have port known, output, 1 bit: 1 means a unique winning class exists; 0 means "don't know".
REQ-014 SHALL have port class_idx, output, $clog2(CLASSES) bits: winning class index.
REQ-015 SHALL have port balance_out, output, BW bits signed: accumulated balance of the winning class.
REQ-016 SHALL have port iters_out, output, $clog2(HEIGHT*PASSES+1) bits: accumulation cycles used by the last run.
REQ-017 BW SHALL equal $clog2(HEIGHT*PASSES*2**WIDTH)+1, so that no accumulator can overflow.

Function
REQ-018 The block SHALL use the FSM states IDLE, RUN and DECIDE.
REQ-019 IDLE with start=1 SHALL:
  - latch pixels;
  - clear all CLASSES balances, pixel index and pass count;
  - go to RUN.
REQ-020 In IDLE with start=0, and in every state other than IDLE, start SHALL be ignored; a start during busy has no effect.
REQ-021 Each RUN cycle at pixel index i SHALL, for every class c, add WEIGHTS[c][i] to balance c if latched pixel i is 1, and subtract it if pixel i is 0.
REQ-022 The pixel index SHALL wrap from HEIGHT-1 to 0 and increment the pass count; the iteration counter increments every RUN cycle.
REQ-023 After the accumulation with index HEIGHT-1 in pass PASSES-1, the FSM SHALL go to DECIDE.
REQ-024 DECIDE (one cycle) SHALL register the following, return to IDLE, and assert done for exactly that following cycle:
  - class_idx = lowest index holding the maximum balance;
  - balance_out = that maximum;
  - known = 1 only if no other class equals the maximum;
  - iters_out.
REQ-025 Full-run latency SHALL be HEIGHT*PASSES+1 rising edges from the edge sampling start to the edge raising done.
REQ-026 Results SHALL hold stable from done until the next done; busy SHALL be 0 whenever done is 1.
REQ-027 Balance arithmetic SHALL be signed, BW bits, with no saturation.

Reset
REQ-028 On rst=0 at a rising edge the block SHALL:
  - enter IDLE;
  - drive busy, done, known, class_idx, balance_out and iters_out to 0;
  - clear balances and counters.
REQ-029 Reset mid-run SHALL abort the run without any done pulse; rst=0 SHALL dominate start in the same cycle.

Configuration
REQ-030 With macro RUN_NETWORK_EARLY_EXIT_EN defined, at each pass wrap (after index HEIGHT-1 is accumulated) the FSM SHALL go to DECIDE early if leader minus runner-up is at least MARGIN.
REQ-031 Without RUN_NETWORK_EARLY_EXIT_EN, every run SHALL take the full HEIGHT*PASSES cycles, and MARGIN SHALL be unused.

Verification (defaults; class0 weights +60, class1 weights -60, class2 weights 0; macro undefined unless stated)
REQ-032 Scenario 1: pixels=7'b1111111, start pulse -> done 29 edges later; known=1, class_idx=0, balance_out=1680, iters_out=28.
REQ-033 Scenario 2: pixels=7'b0000000 -> known=1, class_idx=1, balance_out=1680, iters_out=28.
REQ-034 Scenario 3: macro defined, pixels=7'b1111111 -> done 8 edges after start; class_idx=0, balance_out=420, iters_out=7.
REQ-035 Scenario 4: class0 and class1 both all +60, pixels all 1 -> known=0, class_idx=0, balance_out=1680.
REQ-036 Scenario 5: second start pulse 10 cycles into a run -> ignored; single done at edge 29, results as in Scenario 1.
REQ-037 Scenario 6: rst=0 at cycle 12 of a run -> no done pulse; all outputs 0; next start completes normally.
